// File: rtl/xbar_cfg_loader.sv
// Crossbar configuration loader: streams a 300-bit select image into a shadow register,
// range-checks every field, then commits it atomically. Optional readback: XBAR_CFG_READBACK_EN.
module xbar_cfg_loader #(
    parameter int unsigned N_IN      = 38,
    parameter int unsigned N_OUT     = 50,
    parameter int unsigned SEL_W     = 6,
    parameter int unsigned WORD_W    = 16,
    localparam int unsigned CFG_BITS  = N_OUT * SEL_W,
    localparam int unsigned NUM_WORDS = (CFG_BITS + WORD_W - 1) / WORD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_start,
    input  logic                io_abort,
    input  logic                io_cfg_valid,
    output logic                io_cfg_ready,
    input  logic [WORD_W-1:0]   io_cfg_data,
    output logic                io_busy,
    output logic                io_done,
    output logic                io_err,
    output logic [4:0]          io_word_cnt,
`ifdef XBAR_CFG_READBACK_EN
    input  logic                io_rb_req,
    output logic                io_rb_valid,
    output logic [WORD_W-1:0]   io_rb_data,
`endif
    output logic [CFG_BITS-1:0] io_mux_configs
);

    localparam int unsigned LAST_W = CFG_BITS - (NUM_WORDS - 1) * WORD_W;
    localparam int unsigned PAD_W  = NUM_WORDS * WORD_W - CFG_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_COMMIT
`ifdef XBAR_CFG_READBACK_EN
        , S_RDBK
`endif
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CFG_BITS-1:0]  r_shadow;
    logic [CFG_BITS-1:0]  r_active;
    logic [4:0]           r_word_cnt;
    logic [5:0]           r_fld;
    logic                 r_bad;
    logic                 r_err;
    logic                 r_done;
    logic                 w_cfg_ready;
    logic                 w_hs;
    logic                 w_last_word;
    logic                 w_last_fld;
    logic [SEL_W-1:0]     w_field;
    logic                 w_field_bad;

    assign w_cfg_ready = (r_state == S_LOAD);
    assign w_hs        = io_cfg_valid && w_cfg_ready;
    assign w_last_word = (r_word_cnt == 5'(NUM_WORDS - 1));
    assign w_last_fld  = (r_fld == 6'(N_OUT - 1));
    assign w_field     = r_shadow[32'(r_fld) * SEL_W +: SEL_W];
    assign w_field_bad = (32'(w_field) >= N_IN);

`ifdef XBAR_CFG_READBACK_EN
    logic [4:0]                  r_rb_cnt;
    logic [NUM_WORDS*WORD_W-1:0] w_active_pad;

    assign w_active_pad = {{PAD_W{1'b0}}, r_active};
    assign io_rb_valid  = (r_state == S_RDBK);
    assign io_rb_data   = (r_state == S_RDBK) ? w_active_pad[32'(r_rb_cnt) * WORD_W +: WORD_W] : '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (io_start) begin
                    w_state_nxt = S_LOAD;
`ifdef XBAR_CFG_READBACK_EN
                end else if (io_rb_req) begin
                    w_state_nxt = S_RDBK;
`endif
                end
            end
            S_LOAD: begin
                if (io_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hs && w_last_word) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (io_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last_fld) begin
                    w_state_nxt = (r_bad || w_field_bad) ? S_IDLE : S_COMMIT;
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
`ifdef XBAR_CFG_READBACK_EN
            S_RDBK: begin
                if (r_rb_cnt == 5'(NUM_WORDS - 1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow   <= '0;
            r_active   <= '0;
            r_word_cnt <= '0;
            r_fld      <= '0;
            r_bad      <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
`ifdef XBAR_CFG_READBACK_EN
            r_rb_cnt   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_start) begin
                        r_word_cnt <= '0;
                        r_err      <= 1'b0;
                        r_fld      <= '0;
                        r_bad      <= 1'b0;
`ifdef XBAR_CFG_READBACK_EN
                    end else if (io_rb_req) begin
                        r_rb_cnt <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    // abort wins over a handshake in the same cycle
                    if (w_hs && !io_abort) begin
                        for (int unsigned k = 0; k < NUM_WORDS - 1; k++) begin
                            if (r_word_cnt == 5'(k)) begin
                                r_shadow[k*WORD_W +: WORD_W] <= io_cfg_data;
                            end
                        end
                        if (w_last_word) begin
                            r_shadow[CFG_BITS-1 -: LAST_W] <= io_cfg_data[LAST_W-1:0];
                        end
                        r_word_cnt <= r_word_cnt + 5'd1;
                    end
                end
                S_CHECK: begin
                    if (!io_abort) begin
                        r_fld <= r_fld + 6'd1;
                        if (w_field_bad) begin
                            r_bad <= 1'b1;
                        end
                        if (w_last_fld && (r_bad || w_field_bad)) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_active <= r_shadow;
                    r_done   <= 1'b1;
                end
`ifdef XBAR_CFG_READBACK_EN
                S_RDBK: r_rb_cnt <= r_rb_cnt + 5'd1;
`endif
                default: ;
            endcase
        end
    end

    assign io_cfg_ready   = w_cfg_ready;
    assign io_busy        = (r_state != S_IDLE);
    assign io_done        = r_done;
    assign io_err         = r_err;
    assign io_word_cnt    = r_word_cnt;
    assign io_mux_configs = r_active;

endmodule

// File: doc/xbar_cfg_loader.md
Name: xbar_cfg_loader

Overview:
- Configuration controller for the LUT-tile crossbar: 38 inputs, 50 outputs, one 6-bit select per output, 300 config bits in total.
- Accepts a config image as a stream of 16-bit words over a valid/ready handshake and assembles it in a shadow register.
- Range-checks every select field, then commits the image atomically to the active `io_mux_configs` bus that drives the crossbar.
- The crossbar never sees a partial or illegal configuration.

Parameters:
- N_IN, 38, crossbar input count; a legal select is < N_IN.
- N_OUT, 50, crossbar output count (number of select fields).
- SEL_W, 6, bits per select field.
- WORD_W, 16, config stream word width.
- Derived: CFG_BITS = N_OUT*SEL_W = 300; NUM_WORDS = ceil(CFG_BITS/WORD_W) = 19.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_start  in  1  begin a load; honoured only in IDLE.
- io_abort  in  1  cancel a load; honoured in LOAD and CHECK.
- io_cfg_valid  in  1  config word valid.
- io_cfg_ready  out  1  loader accepts a word this cycle.
- io_cfg_data  in  WORD_W  config word; word k holds bits [16k+15:16k].
- io_busy  out  1  high in any state other than IDLE.
- io_done  out  1  one-cycle pulse when a load completes, either committed or rejected.
- io_err  out  1  last load rejected; sticky until the next accepted io_start.
- io_word_cnt  out  5  words accepted in the current load.
- io_mux_configs  out  CFG_BITS  active config driving the crossbar.

Behaviour:
- Reset, asserted asynchronously (reset=0):
  - state=IDLE; io_mux_configs=0, so every output selects input 0.
  - Shadow register=0; io_cfg_ready, io_busy, io_done, io_err=0; io_word_cnt=0.
  - Reset mid-load also clears the active config.
- FSM states: IDLE, LOAD, CHECK, COMMIT.
- IDLE:
  - io_start=1 -> LOAD; word count cleared; io_err cleared.
  - io_start is ignored in every other state.
- LOAD:
  - io_cfg_ready=1.
  - Each valid&&ready edge writes io_cfg_data into shadow word slot io_word_cnt, then increments the count.
  - Word 18 contributes only bits [11:0]; bits [15:12] are ignored.
  - Acceptance of word NUM_WORDS-1 -> CHECK, with io_cfg_ready deasserting the next cycle.
  - No back-pressure limit: valid may stall indefinitely.
- CHECK:
  - One field checked per cycle, fields 0..49 in order.
  - Any field >= N_IN (values 38..63) sets an internal bad flag.
  - After field 49: bad=0 -> COMMIT; bad=1 -> IDLE with io_err=1 and io_done pulsed; active config unchanged.
- COMMIT:
  - Shadow copied to io_mux_configs in one edge; io_done asserted at that same edge for exactly one cycle.
  - Then IDLE.
- Latency: with the last word accepted at edge E0, io_mux_configs and io_done update at edge E0+51 (50 CHECK cycles + 1 COMMIT).
- io_abort:
  - In LOAD/CHECK: -> IDLE next edge; shadow discarded; active config unchanged; no io_done; io_err unchanged.
  - Abort has priority over a simultaneous handshake.
  - Ignored in IDLE/COMMIT.
- io_start and io_abort asserted together in IDLE: start wins.
- io_mux_configs changes only at a COMMIT edge or on reset.

Optional Feature:
- Macro: XBAR_CFG_READBACK_EN.
- When defined, three ports are added:
  - io_rb_req in 1.
  - io_rb_valid out 1.
  - io_rb_data out WORD_W.
- io_rb_req in IDLE enters state RDBK, which streams the active config as 19 words on 19 consecutive cycles (word 0 first; word 18 zero-padded in [15:12]) with io_rb_valid=1, then returns to IDLE.
- In RDBK, io_busy=1 and io_start is ignored; io_rb_req outside IDLE is ignored.
- Reset values: io_rb_valid=0, io_rb_data=0.
- When undefined, these ports and the RDBK state are absent and the behaviour is as above.

Test Plan:
- Reset, then 19 words with every field = 5 (word pattern from the bit-packing) -> io_done at E0+51; every 6-bit slice of io_mux_configs = 5; io_err=0.
- Valid load, then a second load with field 49 = 45 -> io_done with io_err=1; io_mux_configs keeps the first image; a next io_start clears io_err.
- io_cfg_valid toggled 1/0 on alternate cycles during LOAD -> io_word_cnt steps 0..19 only on handshakes; commit value correct.
- io_abort after 7 words, then io_start and a full load -> no io_done from the aborted load; final config matches the second image only.
- reset pulsed low during CHECK after one commit -> io_mux_configs=0, io_busy=0 immediately (asynchronous); a subsequent load works.
- With XBAR_CFG_READBACK_EN: commit a known image, pulse io_rb_req -> 19 consecutive io_rb_valid cycles whose data equals the loaded words (word 18 masked to [11:0]).
